// File: rtl/dmem_block_responder_pkg.sv
// Shared constants and types for the block-granular data memory responder.
// Default geometry, latency and state codes used by the memory, the cache and the bench.
package dmem_block_responder_pkg;

  localparam int DMEM_ADDR_W  = 6;
  localparam int DMEM_BLOCK_W = 32;
  localparam int DMEM_LATENCY = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } dmem_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } dmem_op_e;

endpackage

// File: rtl/dmem_block_responder_array.sv
// Block storage for the data memory: synchronous write, registered read port.
// Storage is never reset; only the read register returns to zero on reset.
module dmem_block_array
  import dmem_block_responder_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int BLOCK_W = DMEM_BLOCK_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic               re,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [BLOCK_W-1:0] wdata,
  output logic [BLOCK_W-1:0] rdata
);

  logic [BLOCK_W-1:0] mem [2**ADDR_W];
  logic [BLOCK_W-1:0] rdata_q;
  logic [BLOCK_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_block_responder.sv
// Data-memory responder for cache refill/write-back: one block access per request,
// busywait held for a fixed latency, then a single idle-looking response cycle.
module dmem_block_responder
  import dmem_block_responder_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int BLOCK_W = DMEM_BLOCK_W,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [ADDR_W-1:0]  mem_address,
  input  logic [BLOCK_W-1:0] mem_writedata,
  output logic [BLOCK_W-1:0] mem_readdata,
  output logic               mem_busywait
);

  localparam int               CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  dmem_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BLOCK_W-1:0] wdata_q, wdata_d;
  dmem_op_e           op_q, op_d;

  logic req;
  logic done;
  logic arr_we;
  logic arr_re;

  assign req  = mem_read | mem_write;
  assign done = (state_q == S_ACCESS) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = mem_address;
          wdata_d = mem_writedata;
          // A simultaneous read+write is illegal from the cache; resolve it as a write.
          if (mem_write) begin
            op_d = OP_WRITE;
          end else begin
            op_d = OP_READ;
          end
          cnt_d   = CNT_LOAD;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        // Requests still present here belong to the finished access; never re-accept them.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    op_q    <= op_d;
  end

  // A reset landing on the completing cycle must abort the array update as well.
  assign arr_we = done && (op_q == OP_WRITE) && !RESET;
  assign arr_re = done && (op_q == OP_READ) && !RESET;

  dmem_block_array #(
    .ADDR_W  (ADDR_W),
    .BLOCK_W (BLOCK_W)
  ) u_array (
    .clk   (CLK),
    .rst   (RESET),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (mem_readdata)
  );

  assign mem_busywait = ((state_q == S_IDLE) && req) || (state_q == S_ACCESS);

endmodule
